// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the up/down limit counter family.
//   MODE_* : Mode input encoding (wrap vs saturate at the limits)
//   DIR_*  : Dir input encoding (count up vs count down)
//   *_DEF  : default widths used by counter_updown_lim
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

   localparam int BIT_WIDTH_DEF  = 8;
   localparam int STEP_WIDTH_DEF = 4;
   localparam int PRE_WIDTH_DEF  = 4;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: enable divider producing one tick every div+1 enabled
// cycles. Reusable by timers.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears the count
//   clr   : synchronous clear (lower priority than reset)
//   en    : advance the count; when low the count is frozen
//   div   : divide value; tick fires when count == div
//   tick  : combinational, high on the enabled cycle that completes a period
module counter_prescaler #(
   parameter int PreWidth = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                en,
   input  logic [PreWidth-1:0] div,
   output logic                tick
);

   logic [PreWidth-1:0] count;

   assign tick = en && (count == div);

   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (en)
         count <= tick ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/counter_updown_lim.sv
// counter_updown_lim: up/down counter with programmable step, inclusive
// low/high limits, wrap or saturate behaviour, enable prescaler, terminal-count
// pulse and limit-error flag. Drives a tri-state bus copy plus a local copy.
//   Clk, Reset   : clock; synchronous active-high reset
//   Load         : active low parallel load of D (wins over stepping)
//   Enable       : advances the prescaler; a step fires on its tick
//   Dir, Mode    : 0 up / 1 down ; 0 wrap / 1 saturate
//   Step, PreDiv : step magnitude (0 = hold) ; step every PreDiv+1 enables
//   LimLo, LimHi : inclusive limits, sampled every cycle
//   D, OE        : load value ; active low bus output enable
//   Q            : Cnt on the bus when OE=0, else high impedance
//   Cnt, TC      : registered count ; registered one-cycle terminal count
//   LimErr       : registered LimLo > LimHi
module counter_updown_lim
   import counter_pkg::*;
#(
   parameter int BitWidth  = BIT_WIDTH_DEF,
   parameter int StepWidth = STEP_WIDTH_DEF,
   parameter int PreWidth  = PRE_WIDTH_DEF
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Load,
   input  logic                 Enable,
   input  logic                 Dir,
   input  logic                 Mode,
   input  logic [StepWidth-1:0] Step,
   input  logic [PreWidth-1:0]  PreDiv,
   input  logic [BitWidth-1:0]  LimLo,
   input  logic [BitWidth-1:0]  LimHi,
   input  logic [BitWidth-1:0]  D,
   input  logic                 OE,
   output tri   [BitWidth-1:0]  Q,
   output logic [BitWidth-1:0]  Cnt,
   output logic                 TC,
   output logic                 LimErr
);

   logic              step_fire;
   logic              lim_bad;
   logic [BitWidth:0] step_ext;
   logic [BitWidth:0] nxt_wide;
   logic [BitWidth:0] lo_wide;
   logic [BitWidth:0] hi_wide;
   logic [BitWidth-1:0] cnt_nxt;
   logic              tc_nxt;

   // Prescaler only runs on enabled cycles that are not loads; a load clears it.
   counter_prescaler #(.PreWidth(PreWidth)) u_pre (
      .clk   (Clk),
      .reset (Reset),
      .clr   (!Load),
      .en    (Enable && Load),
      .div   (PreDiv),
      .tick  (step_fire)
   );

   // Suppression uses the live compare so a bad limit pair never takes a step,
   // including the first edge on which it appears.
   assign lim_bad  = LimLo > LimHi;

   assign step_ext = {{(BitWidth+1-StepWidth){1'b0}}, Step};
   assign lo_wide  = {1'b0, LimLo};
   assign hi_wide  = {1'b0, LimHi};
   // Extra MSB holds the carry on up steps and the borrow on down steps.
   assign nxt_wide = (Dir == DIR_DOWN) ? ({1'b0, Cnt} - step_ext)
                                       : ({1'b0, Cnt} + step_ext);

   always_comb begin
      cnt_nxt = Cnt;
      tc_nxt  = 1'b0;
      if (Dir == DIR_UP) begin
         tc_nxt = nxt_wide >= hi_wide;
         if (nxt_wide <= hi_wide)
            cnt_nxt = nxt_wide[BitWidth-1:0];
         else
            cnt_nxt = (Mode == MODE_SAT) ? LimHi : LimLo;
      end else begin
         tc_nxt = nxt_wide[BitWidth] || (nxt_wide <= lo_wide);
         if (!nxt_wide[BitWidth] && (nxt_wide >= lo_wide))
            cnt_nxt = nxt_wide[BitWidth-1:0];
         else
            cnt_nxt = (Mode == MODE_SAT) ? LimLo : LimHi;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Cnt    <= '0;
         TC     <= 1'b0;
         LimErr <= 1'b0;
      end else begin
         LimErr <= lim_bad;
         if (!Load) begin
            Cnt <= D;
            TC  <= 1'b0;
         end else if (step_fire && !lim_bad) begin
            Cnt <= cnt_nxt;
            TC  <= tc_nxt;
         end else begin
            TC  <= 1'b0;
         end
      end
   end

   assign Q = OE ? {BitWidth{1'bz}} : Cnt;

endmodule

// File: tb/tb_counter_updown_lim.sv
// tb_counter_updown_lim: directed-vector bench for counter_updown_lim.
// The bus is pulled up so a released Q reads all ones.
module tb_counter_updown_lim;

   logic       Clk = 1'b0;
   logic       Reset, Load, Enable, Dir, Mode, OE;
   logic [3:0] Step, PreDiv;
   logic [7:0] LimLo, LimHi, D;
   wire  [7:0] q_bus;
   logic [7:0] Cnt;
   logic       TC, LimErr;

   int errs   = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (q_bus[i]);
   end

   counter_updown_lim dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .Enable(Enable), .Dir(Dir),
      .Mode(Mode), .Step(Step), .PreDiv(PreDiv), .LimLo(LimLo), .LimHi(LimHi),
      .D(D), .OE(OE), .Q(q_bus), .Cnt(Cnt), .TC(TC), .LimErr(LimErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clk_step();
      @(posedge Clk);
      #1;
   endtask

   // one edge, then check count and terminal count
   task automatic edge_chk(input string tag, input logic [7:0] c, input logic t);
      clk_step();
      chk({tag, ".cnt"}, Cnt, c);
      chk({tag, ".tc"}, TC, t);
   endtask

   initial begin
      Reset = 1'b1; Load = 1'b1; Enable = 1'b0; Dir = 1'b0; Mode = 1'b0;
      OE = 1'b1; Step = 4'd1; PreDiv = 4'd0; LimLo = 8'h00; LimHi = 8'hFF;
      D = 8'h00;
      clk_step();

      // reset mid-count
      Reset = 1'b0; Load = 1'b0; D = 8'h37;
      edge_chk("load37", 8'h37, 1'b0);
      Load = 1'b1; Enable = 1'b1; Reset = 1'b1;
      edge_chk("rst", 8'h00, 1'b0);
      chk("rst.limerr", LimErr, 1'b0);
      chk("rst.q_released", q_bus, 8'hFF);
      OE = 1'b0; #1;
      chk("rst.q_driven", q_bus, 8'h00);

      // up, wrap
      Reset = 1'b0; LimLo = 8'h10; LimHi = 8'h14; Step = 4'd3;
      Load = 1'b0; D = 8'h10;
      edge_chk("upw.load", 8'h10, 1'b0);
      chk("upw.q", q_bus, 8'h10);
      Load = 1'b1;
      edge_chk("upw.1", 8'h13, 1'b0);
      edge_chk("upw.2", 8'h10, 1'b1);
      edge_chk("upw.3", 8'h13, 1'b0);
      edge_chk("upw.4", 8'h10, 1'b1);

      // down, saturate
      Dir = 1'b1; Mode = 1'b1; LimLo = 8'h02; Step = 4'd2;
      Load = 1'b0; D = 8'h05;
      edge_chk("dns.load", 8'h05, 1'b0);
      Load = 1'b1;
      edge_chk("dns.1", 8'h03, 1'b0);
      edge_chk("dns.2", 8'h02, 1'b1);
      edge_chk("dns.3", 8'h02, 1'b1);
      Enable = 1'b0;
      edge_chk("dns.hold", 8'h02, 1'b0);

      // down, wrap through a borrow
      Enable = 1'b1; Mode = 1'b0; LimLo = 8'h00; Load = 1'b0; D = 8'h01;
      edge_chk("dnw.load", 8'h01, 1'b0);
      Load = 1'b1;
      edge_chk("dnw.borrow", 8'h14, 1'b1);

      // prescaler divide by 3
      Dir = 1'b0; LimHi = 8'hFF; Step = 4'd1; PreDiv = 4'd2;
      Load = 1'b0; D = 8'h00;
      edge_chk("pre.load", 8'h00, 1'b0);
      Load = 1'b1;
      edge_chk("pre.1", 8'h00, 1'b0);
      edge_chk("pre.2", 8'h00, 1'b0);
      edge_chk("pre.3", 8'h01, 1'b0);
      edge_chk("pre.4", 8'h01, 1'b0);
      Enable = 1'b0;
      edge_chk("pre.off1", 8'h01, 1'b0);
      edge_chk("pre.off2", 8'h01, 1'b0);
      Enable = 1'b1;
      edge_chk("pre.5", 8'h01, 1'b0);
      edge_chk("pre.6", 8'h02, 1'b0);
      edge_chk("pre.7", 8'h02, 1'b0);

      // load with enable clears the half-run prescaler
      Load = 1'b0; D = 8'hA5;
      edge_chk("ld.a5", 8'hA5, 1'b0);
      Load = 1'b1;
      edge_chk("ld.1", 8'hA5, 1'b0);
      edge_chk("ld.2", 8'hA5, 1'b0);
      edge_chk("ld.3", 8'hA6, 1'b0);
      Load = 1'b0; Reset = 1'b1;
      edge_chk("ld.rst", 8'h00, 1'b0);

      // limit error
      Reset = 1'b0; Load = 1'b1; PreDiv = 4'd0; LimLo = 8'h20; LimHi = 8'h10;
      edge_chk("le.1", 8'h00, 1'b0);
      chk("le.1.flag", LimErr, 1'b1);
      edge_chk("le.2", 8'h00, 1'b0);
      Load = 1'b0; D = 8'h05;
      edge_chk("le.load", 8'h05, 1'b0);
      Load = 1'b1; LimHi = 8'h30;
      edge_chk("le.ok1", 8'h06, 1'b0);
      chk("le.ok1.flag", LimErr, 1'b0);
      edge_chk("le.ok2", 8'h07, 1'b0);

      // saturate up at limit with step 0 still flags TC
      Mode = 1'b1; Step = 4'd0; Load = 1'b0; D = 8'h30;
      edge_chk("s0.load", 8'h30, 1'b0);
      Load = 1'b1;
      edge_chk("s0.1", 8'h30, 1'b1);
      OE = 1'b1; #1;
      chk("s0.q_released", q_bus, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
